detect_tile_collision: RTL and testbench
========================================

# detect_tile_collision

Parametrised successor to the four-way background collision probe. On a start request it scans every tilemap cell bordering a sprite footprint of SPAN×SPAN tiles on all four sides, and treats out-of-map cells as solid. It tolerates a tilemap memory with configurable read latency, and publishes all four side flags atomically at the end of the scan. It sits between the sprite movement controller and the shared tilemap ROM/RAM port.

## Interface
Parameters:
- TILEMAP_W, 2000, map width in tiles
- TILEMAP_H, 16, map height in tiles
- X_W, 11, x coordinate width
- Y_W, 4, y coordinate width
- ADDR_W, 15, tilemap address width
- TILE_W, 4, tile code width
- SPAN, 1, sprite footprint in tiles per side (1..4)
- RD_LAT, 1, tilemap read latency in cycles (1..3)

Ports:
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  start request; sampled only in IDLE
- x_location  in  X_W  footprint left column, in tiles
- y_location  in  Y_W  footprint top row, in tiles (row 0 = top)
- memory_input  in  TILE_W  tile code returned by tilemap
- memory_address  out  ADDR_W  tilemap address, x + y*TILEMAP_W
- mem_rd  out  1  read strobe, one cycle per in-bounds probe
- left / right / up / down  out  1  registered collision flags
- done  out  1  high while idle, low while scanning

## Operation
- Reset values:
  - state IDLE
  - left/right/up/down = 0, done = 1
  - mem_rd = 0, memory_address = 0
- IDLE: when enable=1, latch x_location/y_location, clear the scratch accumulators, and go to PROBE with probe index k=0.
- Probe order: left cells first, then right, then up, then down, with j = 0..SPAN-1 within each side. Total probes = 4*SPAN.
  - left: (x-1, y+j)
  - right: (x+SPAN, y+j)
  - up: (x+j, y-1)
  - down: (x+j, y+SPAN)
- Bounds check: signed compare, column in [0, TILEMAP_W-1] and row in [0, TILEMAP_H-1]. Out of bounds means solid: no read is issued, the side's accumulator is set, and k advances in one cycle.
- PROBE (in bounds): drive memory_address with mem_rd=1 for exactly one cycle, then go to WAIT.
- WAIT: count RD_LAT cycles. On the last one, sample memory_input, OR "solid" into the side accumulator, advance k, and return to PROBE. After the last probe, go to COMMIT.
- COMMIT: copy all four accumulators into left/right/up/down in the same edge, then return to IDLE.
- Solid test: memory_input != 0 (see Configuration).
- memory_address = 0 whenever mem_rd = 0.
- Arithmetic: compute the address at ADDR_W+1 bits and truncate. Parameter legality (TILEMAP_W*TILEMAP_H ≤ 2^ADDR_W) is checked at elaboration.
- enable while busy is ignored; there is no queueing. x/y changes mid-scan have no effect.
- Flags hold their previous values throughout the scan and never show partial results.

## Timing
- Enable is accepted on edge E. done falls after E.
- Each in-bounds probe takes 1+RD_LAT cycles; each out-of-bounds probe takes 1 cycle; COMMIT takes 1 cycle.
- SPAN=1, RD_LAT=1, all probes in bounds: done is low for 9 cycles. Flags update and done rises on the same edge, E+9.
- memory_input is sampled RD_LAT edges after the edge that ended the mem_rd cycle.
- Reset asserted mid-scan: immediate return to IDLE, flags cleared, no commit.
- enable held high continuously: a new scan starts on the edge after done rises, i.e. done is high for one cycle.

## Configuration
- DETECT_TILE_COLLISION_SOLID_MASK_EN
- Defined: adds input solid_mask [2**TILE_W-1:0]. A tile is solid when solid_mask[memory_input] = 1. The mask is sampled per probe.
- Undefined: port absent; a tile is solid when memory_input != 0.
- Out-of-bounds probes count as solid in both builds.

## Structure
- Package tile_collision_pkg holds:
  - state enum (IDLE, PROBE, WAIT, COMMIT)
  - side index constants SIDE_L=0, SIDE_R=1, SIDE_U=2, SIDE_D=3
  - default widths
- Sub-module tile_probe_gen: combinational. Maps (x, y, k) to (column, row, side, in_bounds, address). It isolates the bounds and address arithmetic for standalone checking.

## Test plan
- SPAN=1, RD_LAT=1, x=10, y=5, memory returns 3 only at address 5*2000+9=10009 → reads at 10009, 10011, 8010, 12010 in that order; left=1, others 0; done low 9 cycles.
- x=0, y=0, all tiles 0 → left=1 and up=1 with no reads issued for those probes; right=0, down=0; only 2 mem_rd pulses.
- SPAN=2, RD_LAT=3, x=100, y=4, tile 7 only at (101, 6) → 8 reads; down=1, others 0; done low 8*4+1=33 cycles.
- Flags 1,0,0,0 from the prior scan; new scan starts with all tiles clear → left stays 1 until the COMMIT edge, then all 0 together.
- Reset pulsed during the third probe → flags 0, done=1, mem_rd=0 next cycle. A subsequent enable runs a full scan from k=0.
- Enable pulsed during a scan → ignored; exactly 4*SPAN reads occur for the original request.

Source files
------------

// File: rtl/tile_collision_pkg.sv
// Shared types and constants for the tile collision probe.
// The FSM state encoding, side indices and default geometry live here so
// the probe generator and the top-level controller agree on them.
package tile_collision_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        WAIT,
        COMMIT
    } state_t;

    // Side indices, also the bit positions of the scratch accumulator
    localparam int SIDE_L = 0;
    localparam int SIDE_R = 1;
    localparam int SIDE_U = 2;
    localparam int SIDE_D = 3;

    // Default geometry and timing
    localparam int DEF_TILEMAP_W = 2000;
    localparam int DEF_TILEMAP_H = 16;
    localparam int DEF_X_W       = 11;
    localparam int DEF_Y_W       = 4;
    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_TILE_W    = 4;
    localparam int DEF_SPAN      = 1;
    localparam int DEF_RD_LAT    = 1;

    // Legal ranges for the footprint and memory latency
    localparam int MAX_SPAN   = 4;
    localparam int MAX_RD_LAT = 3;

    // Probe index width: covers 4*MAX_SPAN probes
    localparam int K_W = 4;

    // Latency counter width: covers MAX_RD_LAT cycles
    localparam int LAT_W = 2;

    // Number of probes in one scan for a given footprint
    function automatic int probe_total(input int span);
        return 4 * span;
    endfunction

endpackage

// File: rtl/tile_probe_gen.sv
// Combinational probe coordinate generator for detect_tile_collision.
// Maps the latched footprint origin (x, y) and probe index k to the tile
// being examined: signed column/row, which side it belongs to, whether it
// lies inside the map, and its linear tilemap address.
// Probe order is left, right, up, down with j = 0..SPAN-1 inside each side.
module tile_probe_gen
    import tile_collision_pkg::*;
#(
    parameter int TILEMAP_W = DEF_TILEMAP_W,
    parameter int TILEMAP_H = DEF_TILEMAP_H,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SPAN      = DEF_SPAN
) (
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic [K_W-1:0]        k,
    output logic signed [X_W+1:0] column,
    output logic signed [Y_W+1:0] row,
    output logic [1:0]            side,
    output logic                  in_bounds,
    output logic [ADDR_W-1:0]     address
);

    int side_i;
    int j_i;
    int col_i;
    int row_i;
    logic [ADDR_W:0] addr_wide;

    // Decode k into side and offset, then place the probe cell next to the footprint
    always_comb begin
        side_i = int'(k) / SPAN;
        j_i    = int'(k) % SPAN;
        col_i  = int'(x);
        row_i  = int'(y);
        case (side_i)
            SIDE_L: begin
                col_i = int'(x) - 1;
                row_i = int'(y) + j_i;
            end
            SIDE_R: begin
                col_i = int'(x) + SPAN;
                row_i = int'(y) + j_i;
            end
            SIDE_U: begin
                col_i = int'(x) + j_i;
                row_i = int'(y) - 1;
            end
            default: begin
                col_i = int'(x) + j_i;
                row_i = int'(y) + SPAN;
            end
        endcase
    end

    assign side   = 2'(side_i);
    assign column = (X_W+2)'(col_i);
    assign row    = (Y_W+2)'(row_i);

    // Signed comparison so x-1 at column 0 and y-1 at row 0 fall outside the map
    assign in_bounds = (col_i >= 0) && (col_i < TILEMAP_W) &&
                       (row_i >= 0) && (row_i < TILEMAP_H);

    // One spare bit of headroom, then truncate; only meaningful when in_bounds
    assign addr_wide = (ADDR_W+1)'(col_i) +
                       (ADDR_W+1)'(row_i) * (ADDR_W+1)'(TILEMAP_W);
    assign address   = ADDR_W'(addr_wide);

endmodule

// File: rtl/detect_tile_collision.sv
// Four-way background collision probe for a SPAN x SPAN tile sprite footprint.
// On a start request it walks every tile bordering the footprint (left, right,
// up, down), reads in-bounds tiles from the shared tilemap port with RD_LAT
// cycles of latency, treats out-of-map tiles as solid, and publishes all four
// side flags together once the scan is complete.
// Optional build macro: DETECT_TILE_COLLISION_SOLID_MASK_EN adds a solid_mask
// input that selects which tile codes are solid; without it any nonzero tile
// code is solid.
module detect_tile_collision
    import tile_collision_pkg::*;
#(
    parameter int TILEMAP_W = DEF_TILEMAP_W,
    parameter int TILEMAP_H = DEF_TILEMAP_H,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TILE_W    = DEF_TILE_W,
    parameter int SPAN      = DEF_SPAN,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [X_W-1:0]         x_location,
    input  logic [Y_W-1:0]         y_location,
    input  logic [TILE_W-1:0]      memory_input,
`ifdef DETECT_TILE_COLLISION_SOLID_MASK_EN
    input  logic [2**TILE_W-1:0]   solid_mask,
`endif
    output logic [ADDR_W-1:0]      memory_address,
    output logic                   mem_rd,
    output logic                   left,
    output logic                   right,
    output logic                   up,
    output logic                   down,
    output logic                   done
);

    // Reject geometries the address bus or counters cannot represent
    if (longint'(TILEMAP_W) * longint'(TILEMAP_H) > (longint'(1) << ADDR_W)) begin : g_bad_map
        $error("detect_tile_collision: TILEMAP_W*TILEMAP_H exceeds 2**ADDR_W");
    end
    if (SPAN < 1 || SPAN > MAX_SPAN) begin : g_bad_span
        $error("detect_tile_collision: SPAN must be in 1..4");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("detect_tile_collision: RD_LAT must be in 1..3");
    end

    state_t             state;
    logic [X_W-1:0]     x_lat;
    logic [Y_W-1:0]     y_lat;
    logic [K_W-1:0]     k;
    logic [LAT_W-1:0]   lat_cnt;
    logic [3:0]         acc;

    logic signed [X_W+1:0] probe_column;
    logic signed [Y_W+1:0] probe_row;
    logic [1:0]            probe_side;
    logic                  probe_in_bounds;
    logic [ADDR_W-1:0]     probe_address;

    logic solid;
    logic last_probe;
    logic last_wait;
    logic unused_coords;

    tile_probe_gen #(
        .TILEMAP_W (TILEMAP_W),
        .TILEMAP_H (TILEMAP_H),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .ADDR_W    (ADDR_W),
        .SPAN      (SPAN)
    ) u_probe_gen (
        .x         (x_lat),
        .y         (y_lat),
        .k         (k),
        .column    (probe_column),
        .row       (probe_row),
        .side      (probe_side),
        .in_bounds (probe_in_bounds),
        .address   (probe_address)
    );

    // Column and row are only of interest when checking the generator on its own
    assign unused_coords = ^{probe_column, probe_row};

`ifdef DETECT_TILE_COLLISION_SOLID_MASK_EN
    assign solid = solid_mask[memory_input];
`else
    assign solid = (memory_input != '0);
`endif

    assign last_probe = (k == K_W'(probe_total(SPAN) - 1));
    assign last_wait  = (lat_cnt == LAT_W'(RD_LAT - 1));

    // The read strobe covers exactly the PROBE cycle of an in-bounds cell,
    // so the address bus is parked at zero at all other times
    assign mem_rd         = (state == PROBE) && probe_in_bounds;
    assign memory_address = mem_rd ? probe_address : '0;

    // Scan controller: latch request, walk probes, wait out read latency, commit flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            x_lat   <= '0;
            y_lat   <= '0;
            k       <= '0;
            lat_cnt <= '0;
            acc     <= '0;
            left    <= 1'b0;
            right   <= 1'b0;
            up      <= 1'b0;
            down    <= 1'b0;
            done    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        x_lat   <= x_location;
                        y_lat   <= y_location;
                        k       <= '0;
                        lat_cnt <= '0;
                        acc     <= '0;
                        done    <= 1'b0;
                        state   <= PROBE;
                    end
                end
                PROBE: begin
                    if (probe_in_bounds) begin
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end else begin
                        acc[probe_side] <= 1'b1;
                        if (last_probe) begin
                            state <= COMMIT;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (last_wait) begin
                        acc[probe_side] <= acc[probe_side] | solid;
                        if (last_probe) begin
                            state <= COMMIT;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= PROBE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                COMMIT: begin
                    left  <= acc[SIDE_L];
                    right <= acc[SIDE_R];
                    up    <= acc[SIDE_U];
                    down  <= acc[SIDE_D];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_tile_collision.sv
// Self-checking bench for detect_tile_collision.
// Two instances run side by side: one with SPAN=1/RD_LAT=1 and one with
// SPAN=2/RD_LAT=3. A behavioural tilemap memory answers reads after the
// configured latency (junk before that), and a coordinate-level reference
// model predicts the read sequence, the flags and the scan length.
module tb_detect_tile_collision;

    localparam int MAP_W = 2000;
    localparam int MAP_H = 16;
    localparam int SPAN0 = 1;
    localparam int LAT0  = 1;
    localparam int SPAN1 = 2;
    localparam int LAT1  = 3;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        enable0 = 1'b0;
    logic        enable1 = 1'b0;
    logic [10:0] x0 = '0;
    logic [10:0] x1 = '0;
    logic [3:0]  y0 = '0;
    logic [3:0]  y1 = '0;
    logic [3:0]  mem0 = '0;
    logic [3:0]  mem1 = '0;
    logic [14:0] addr0, addr1;
    logic        rd0, rd1;
    logic        left0, right0, up0, down0, done0;
    logic        left1, right1, up1, down1, done1;

    int total = 0;
    int bad   = 0;

    logic [3:0] tilemap [MAP_W*MAP_H];
    int dirty[$];
    int log0[$];
    int log1[$];
    int zero_err0 = 0;
    int zero_err1 = 0;
    int pend_addr [2];
    int pend_cnt  [2];
    bit pend_on   [2];

    int         exp_reads[$];
    logic [3:0] exp_flags;
    int         exp_cycles;

    always #5 clock = ~clock;

    detect_tile_collision #(.SPAN(SPAN0), .RD_LAT(LAT0)) dut0 (
        .clock          (clock),
        .resetn         (resetn),
        .enable         (enable0),
        .x_location     (x0),
        .y_location     (y0),
        .memory_input   (mem0),
`ifdef DETECT_TILE_COLLISION_SOLID_MASK_EN
        .solid_mask     (16'hFFFE),
`endif
        .memory_address (addr0),
        .mem_rd         (rd0),
        .left           (left0),
        .right          (right0),
        .up             (up0),
        .down           (down0),
        .done           (done0)
    );

    detect_tile_collision #(.SPAN(SPAN1), .RD_LAT(LAT1)) dut1 (
        .clock          (clock),
        .resetn         (resetn),
        .enable         (enable1),
        .x_location     (x1),
        .y_location     (y1),
        .memory_input   (mem1),
`ifdef DETECT_TILE_COLLISION_SOLID_MASK_EN
        .solid_mask     (16'hFFFE),
`endif
        .memory_address (addr1),
        .mem_rd         (rd1),
        .left           (left1),
        .right          (right1),
        .up             (up1),
        .down           (down1),
        .done           (done1)
    );

    function automatic logic [3:0] memReply(input int d, input int lat);
        if (pend_on[d] && pend_cnt[d] == lat && pend_addr[d] < MAP_W*MAP_H)
            return tilemap[pend_addr[d]];
        return 4'($urandom_range(1, 15));
    endfunction

    // Tilemap memory: data is valid only in the cycle RD_LAT edges after the strobe
    always @(negedge clock) begin
        if (!rd0 && addr0 != '0) zero_err0++;
        if (rd0) begin
            pend_addr[0] = int'(addr0);
            pend_cnt[0]  = 0;
            pend_on[0]   = 1'b1;
            log0.push_back(int'(addr0));
        end else if (pend_on[0]) begin
            pend_cnt[0]++;
        end
        mem0 = memReply(0, LAT0);

        if (!rd1 && addr1 != '0) zero_err1++;
        if (rd1) begin
            pend_addr[1] = int'(addr1);
            pend_cnt[1]  = 0;
            pend_on[1]   = 1'b1;
            log1.push_back(int'(addr1));
        end else if (pend_on[1]) begin
            pend_cnt[1]++;
        end
        mem1 = memReply(1, LAT1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] flagsOf(input int d);
        return (d == 0) ? {left0, right0, up0, down0} : {left1, right1, up1, down1};
    endfunction

    function automatic logic doneOf(input int d);
        return (d == 0) ? done0 : done1;
    endfunction

    task automatic drive(input int d, input logic en, input int xi, input int yi);
        if (d == 0) begin
            enable0 = en; x0 = 11'(xi); y0 = 4'(yi);
        end else begin
            enable1 = en; x1 = 11'(xi); y1 = 4'(yi);
        end
    endtask

    task automatic driveEnable(input int d, input logic en);
        if (d == 0) enable0 = en;
        else        enable1 = en;
    endtask

    task automatic setTile(input int c, input int r, input logic [3:0] v);
        tilemap[c + r*MAP_W] = v;
        dirty.push_back(c + r*MAP_W);
    endtask

    task automatic clearTiles();
        while (dirty.size() > 0) tilemap[dirty.pop_back()] = 4'd0;
    endtask

    // Reference: enumerate the border cells side by side and price each probe
    task automatic computeExpected(input int span, input int lat, input int xi, input int yi);
        int c, r;
        exp_reads.delete();
        exp_flags  = '0;
        exp_cycles = 1;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < span; j++) begin
                case (s)
                    0:       begin c = xi - 1;    r = yi + j;    end
                    1:       begin c = xi + span; r = yi + j;    end
                    2:       begin c = xi + j;    r = yi - 1;    end
                    default: begin c = xi + j;    r = yi + span; end
                endcase
                if (c < 0 || c >= MAP_W || r < 0 || r >= MAP_H) begin
                    exp_flags[3-s] = 1'b1;
                    exp_cycles += 1;
                end else begin
                    exp_reads.push_back(c + r*MAP_W);
                    if (tilemap[c + r*MAP_W] != 4'd0) exp_flags[3-s] = 1'b1;
                    exp_cycles += 1 + lat;
                end
            end
        end
    endtask

    // Run one scan on instance d and compare it against the reference model
    task automatic applyStimulus(input int d, input int xi, input int yi, input bit poke);
        int span, lat, cnt, zerr;
        logic [3:0] prev;
        bit held;
        int got[$];
        span = (d == 0) ? SPAN0 : SPAN1;
        lat  = (d == 0) ? LAT0  : LAT1;
        computeExpected(span, lat, xi, yi);
        @(negedge clock);
        log0.delete(); log1.delete();
        zero_err0 = 0; zero_err1 = 0;
        prev = flagsOf(d);
        drive(d, 1'b1, xi, yi);
        @(posedge clock); #1;
        drive(d, 1'b0, int'($urandom_range(0, MAP_W-1)), int'($urandom_range(0, MAP_H-1)));
        checkOutput("done_fall", 32'(doneOf(d)), 32'd0);
        cnt  = 0;
        held = 1'b1;
        while (doneOf(d) !== 1'b1 && cnt < 400) begin
            if (flagsOf(d) !== prev) held = 1'b0;
            if (poke) driveEnable(d, cnt == 3);
            @(posedge clock); #1;
            cnt++;
        end
        driveEnable(d, 1'b0);
        checkOutput("done_low_cycles", 32'(cnt), 32'(exp_cycles));
        checkOutput("flags_held", 32'(held), 32'd1);
        checkOutput("flags", 32'(flagsOf(d)), 32'(exp_flags));
        if (d == 0) begin got = log0; zerr = zero_err0; end
        else        begin got = log1; zerr = zero_err1; end
        checkOutput("read_count", 32'(got.size()), 32'(exp_reads.size()));
        for (int i = 0; i < got.size() && i < exp_reads.size(); i++)
            checkOutput($sformatf("read_addr%0d", i), 32'(got[i]), 32'(exp_reads[i]));
        checkOutput("addr_idle_zero", 32'(zerr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        for (int i = 0; i < MAP_W*MAP_H; i++) tilemap[i] = 4'd0;
        for (int d = 0; d < 2; d++) begin
            pend_on[d] = 1'b0; pend_cnt[d] = 0; pend_addr[d] = 0;
        end

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_flags0", 32'(flagsOf(0)), 32'd0);
        checkOutput("rst_done0", 32'(done0), 32'd1);
        checkOutput("rst_rd0", 32'(rd0), 32'd0);
        checkOutput("rst_addr0", 32'(addr0), 32'd0);
        checkOutput("rst_done1", 32'(done1), 32'd1);
        checkOutput("rst_flags1", 32'(flagsOf(1)), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Single solid tile to the left of the footprint
        setTile(9, 5, 4'd3);
        applyStimulus(0, 10, 5, 1'b0);

        // Left flag must survive until the commit edge of a clear scan
        clearTiles();
        applyStimulus(0, 10, 5, 1'b0);

        // Top-left map corner: left and up are outside the map
        applyStimulus(0, 0, 0, 1'b0);

        // Wide footprint, slow memory, one solid tile below
        setTile(101, 6, 4'd7);
        applyStimulus(1, 100, 4, 1'b0);
        clearTiles();

        // Enable pulsed mid-scan is ignored
        setTile(51, 6, 4'd2);
        applyStimulus(0, 50, 7, 1'b1);
        applyStimulus(1, 1999, 14, 1'b1);
        clearTiles();

        // Enable held high: done is high for exactly one cycle between scans
        @(negedge clock);
        drive(0, 1'b1, 10, 5);
        @(posedge clock); #1;
        cnt = 0;
        while (done0 !== 1'b1 && cnt < 400) begin
            @(posedge clock); #1;
            cnt++;
        end
        @(posedge clock); #1;
        checkOutput("hold_restart", 32'(done0), 32'd0);
        drive(0, 1'b0, 10, 5);
        cnt = 0;
        while (done0 !== 1'b1 && cnt < 400) begin
            @(posedge clock); #1;
            cnt++;
        end
        checkOutput("hold_second_done", 32'(done0), 32'd1);

        // Reset during the third probe aborts the scan without a commit
        setTile(9, 5, 4'd3);
        applyStimulus(0, 10, 5, 1'b0);
        @(negedge clock);
        log0.delete();
        drive(0, 1'b1, 10, 5);
        @(posedge clock); #1;
        drive(0, 1'b0, 10, 5);
        cnt = 0;
        while (log0.size() < 3 && cnt < 100) begin
            @(negedge clock); #1;
            cnt++;
        end
        checkOutput("third_probe_seen", 32'(log0.size()), 32'd3);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_flags0", 32'(flagsOf(0)), 32'd0);
        checkOutput("midrst_done0", 32'(done0), 32'd1);
        checkOutput("midrst_rd0", 32'(rd0), 32'd0);
        checkOutput("midrst_flags1", 32'(flagsOf(1)), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(0, 10, 5, 1'b0);
        clearTiles();

        // Randomised placements, biased towards the map edges
        for (int it = 0; it < 24; it++) begin
            int d, span, xi, yi;
            d    = it % 2;
            span = (d == 0) ? SPAN0 : SPAN1;
            case ($urandom_range(0, 3))
                0:       xi = int'($urandom_range(0, 2));
                1:       xi = int'($urandom_range(MAP_W-4, MAP_W-1));
                default: xi = int'($urandom_range(0, MAP_W-1));
            endcase
            yi = int'($urandom_range(0, MAP_H-1));
            clearTiles();
            for (int c = xi - 1; c <= xi + span; c++)
                for (int r = yi - 1; r <= yi + span; r++)
                    if (c >= 0 && c < MAP_W && r >= 0 && r < MAP_H && $urandom_range(0, 2) == 0)
                        setTile(c, r, 4'($urandom_range(1, 15)));
            applyStimulus(d, xi, yi, (it % 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
